// File: rtl/bus_memory_unit.sv
// Program/data memory for the CPU. It services one read or write request at
// a time through a fixed wait-state sequence and signals completion with a
// one-cycle mem_ready pulse. A side port preloads words while the unit is idle.
module bus_memory_unit #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] data_out,
  output logic              mem_ready,
  output logic              busy,
  output logic              err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [3:0]  WAIT_INIT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_is_write;
  logic [DATA_W-1:0] r_data_out;
  logic              r_mem_ready;
  logic              r_busy;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_valid_req;
  logic w_illegal_req;

  // Classify the request lines: exactly one high is a transaction, both high is an error
  always_comb begin
    w_valid_req   = mem_read ^ mem_write;
    w_illegal_req = mem_read & mem_write;
  end

  // Transaction FSM, memory array and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_is_write  <= 1'b0;
      r_data_out  <= '0;
      r_mem_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_valid_req) begin
            r_addr     <= addr;
            r_wdata    <= wdata;
            r_is_write <= mem_write;
            r_busy     <= 1'b1;
            r_cnt      <= WAIT_INIT;
            r_state    <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
          end else if (w_illegal_req) begin
            r_err <= 1'b1;
          end else if (ld_en) begin
            r_mem[ld_addr] <= ld_data;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= S_ACCESS;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ACCESS: begin
          if (r_is_write) begin
            r_mem[r_addr] <= r_wdata;
          end else begin
            r_data_out <= r_mem[r_addr];
          end
          r_mem_ready <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          r_mem_ready <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_out  = r_data_out;
  assign mem_ready = r_mem_ready;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_bus_memory_unit.sv
// Bench for bus_memory_unit: directed scenarios plus a randomized mix of reads,
// writes, preloads and illegal requests, checked against an array model.
module tb_bus_memory_unit;

  localparam int W = 2;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  // Main instance (two wait states)
  logic       reset;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic       mem_read, mem_write, ld_en;
  logic [4:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] data_out;
  logic       mem_ready, busy, err;

  // Zero-wait instance
  logic       z_reset;
  logic [4:0] z_addr;
  logic [7:0] z_wdata;
  logic       z_mem_read, z_mem_write, z_ld_en;
  logic [4:0] z_ld_addr;
  logic [7:0] z_ld_data;
  logic [7:0] z_data_out;
  logic       z_mem_ready, z_busy, z_err;

  bus_memory_unit #(.DATA_W(8), .ADDR_W(5), .WAIT_CYCLES(W)) dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata),
    .mem_read(mem_read), .mem_write(mem_write), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data), .data_out(data_out),
    .mem_ready(mem_ready), .busy(busy), .err(err)
  );

  bus_memory_unit #(.DATA_W(8), .ADDR_W(5), .WAIT_CYCLES(0)) dut_z (
    .clock(clock), .reset(z_reset), .addr(z_addr), .wdata(z_wdata),
    .mem_read(z_mem_read), .mem_write(z_mem_write), .ld_en(z_ld_en),
    .ld_addr(z_ld_addr), .ld_data(z_ld_data), .data_out(z_data_out),
    .mem_ready(z_mem_ready), .busy(z_busy), .err(z_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: memory contents and the value data_out should hold
  logic [7:0] model [32];
  logic [7:0] exp_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    exp_dout = 8'h00;
  endtask

  // One CPU transaction; request held until mem_ready is seen, addr/wdata
  // scrambled meanwhile (must be ignored). ld_clash drives a preload in the
  // accepting cycle, ld_during drives preloads while busy; both must be dropped.
  task automatic cpu_txn(input bit is_wr, input logic [4:0] a, input logic [7:0] d,
                         input bit ld_clash, input bit ld_during);
    int seen   = -1;
    int busy_n = 0;
    @(negedge clock);
    mem_read  = !is_wr;
    mem_write = is_wr;
    addr      = a;
    wdata     = d;
    if (ld_clash) begin
      ld_en = 1'b1; ld_addr = 5'($urandom); ld_data = 8'($urandom);
    end
    @(posedge clock);
    for (int k = 1; k <= 40 && seen < 0; k++) begin
      @(negedge clock);
      if (busy) busy_n++;
      if (mem_ready) seen = k;
      check("err_idle_txn", 32'(err), 32'd0);
      if (seen >= 0) begin
        mem_read = 1'b0; mem_write = 1'b0; ld_en = 1'b0;
      end else begin
        addr  = 5'($urandom);
        wdata = 8'($urandom);
        ld_en = ld_during;
        if (ld_during) begin
          ld_addr = (k == 1) ? a : 5'($urandom);
          ld_data = 8'($urandom);
        end
      end
    end
    mem_read = 1'b0; mem_write = 1'b0; ld_en = 1'b0;
    check("ready_latency", 32'(seen), 32'(W + 2));
    check("busy_cycles", 32'(busy_n), 32'(W + 2));
    if (is_wr) model[a] = d;
    else       exp_dout = model[a];
    @(negedge clock);
    check("ready_pulse_end", 32'(mem_ready), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
    check("data_out", 32'(data_out), 32'(exp_dout));
  endtask

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    @(negedge clock);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clock);
    ld_en = 1'b0;
    model[a] = d;
    check("pl_ready", 32'(mem_ready), 32'd0);
    check("pl_err", 32'(err), 32'd0);
    check("pl_busy", 32'(busy), 32'd0);
    check("pl_dout", 32'(data_out), 32'(exp_dout));
  endtask

  task automatic illegal_req();
    @(negedge clock);
    mem_read = 1'b1; mem_write = 1'b1;
    addr = 5'($urandom); wdata = 8'($urandom);
    @(negedge clock);
    check("ill_err", 32'(err), 32'd1);
    check("ill_busy", 32'(busy), 32'd0);
    check("ill_ready", 32'(mem_ready), 32'd0);
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clock);
    check("ill_err_end", 32'(err), 32'd0);
    check("ill_dout", 32'(data_out), 32'(exp_dout));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int busy_n;
    reset = 1'b1; z_reset = 1'b1;
    addr = '0; wdata = '0; mem_read = 0; mem_write = 0; ld_en = 0; ld_addr = '0; ld_data = '0;
    z_addr = '0; z_wdata = '0; z_mem_read = 0; z_mem_write = 0; z_ld_en = 0; z_ld_addr = '0; z_ld_data = '0;
    model_clear();
    #12;
    check("rst_dout", 32'(data_out), 32'd0);
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clock);
    reset = 1'b0; z_reset = 1'b0;

    // 1: read of a cleared word
    cpu_txn(1'b0, 5'd5, 8'h00, 1'b0, 1'b0);
    // 2: preload then read back
    preload(5'd3, 8'hA5);
    cpu_txn(1'b0, 5'd3, 8'h00, 1'b0, 1'b0);
    // 3: write does not disturb data_out; top address
    cpu_txn(1'b1, 5'd31, 8'h3C, 1'b0, 1'b0);
    check("dout_after_write", 32'(data_out), 32'hA5);
    cpu_txn(1'b0, 5'd31, 8'h00, 1'b0, 1'b0);
    // 4: illegal request, and preload attempts while busy
    illegal_req();
    cpu_txn(1'b0, 5'd3, 8'h00, 1'b0, 1'b1);
    cpu_txn(1'b0, 5'd3, 8'h00, 1'b1, 1'b0);
    // 5: reset during the wait phase of a write
    @(negedge clock);
    mem_write = 1'b1; addr = 5'd7; wdata = 8'hFF;
    @(posedge clock);
    @(negedge clock);
    check("r5_busy_before", 32'(busy), 32'd1);
    reset = 1'b1; mem_write = 1'b0;
    #1;
    check("r5_busy", 32'(busy), 32'd0);
    check("r5_ready", 32'(mem_ready), 32'd0);
    check("r5_dout", 32'(data_out), 32'd0);
    model_clear();
    @(negedge clock);
    reset = 1'b0;
    cpu_txn(1'b0, 5'd7, 8'h00, 1'b0, 1'b0);
    cpu_txn(1'b0, 5'd3, 8'h00, 1'b0, 1'b0);

    // Randomized mix
    for (int it = 0; it < 80; it++) begin
      int unsigned op = $urandom_range(0, 9);
      logic [4:0] a = 5'($urandom);
      logic [7:0] d = 8'($urandom);
      if (op <= 3)      cpu_txn(1'b0, a, d, 1'($urandom), 1'($urandom));
      else if (op <= 6) cpu_txn(1'b1, a, d, 1'($urandom), 1'($urandom));
      else if (op <= 8) preload(a, d);
      else              illegal_req();
    end
    for (int i = 0; i < 32; i++) cpu_txn(1'b0, 5'(i), 8'h00, 1'b0, 1'b0);

    // 6: zero-wait instance, address changed right after acceptance
    @(negedge clock);
    z_ld_en = 1'b1; z_ld_addr = 5'd2; z_ld_data = 8'h11;
    @(negedge clock);
    z_ld_en = 1'b0;
    z_mem_read = 1'b1; z_addr = 5'd2;
    @(posedge clock);
    seen = -1; busy_n = 0;
    for (int k = 1; k <= 40 && seen < 0; k++) begin
      @(negedge clock);
      if (z_busy) busy_n++;
      if (z_mem_ready) seen = k;
      z_addr = 5'd9;
    end
    z_mem_read = 1'b0;
    check("z_ready_latency", 32'(seen), 32'd2);
    check("z_busy_cycles", 32'(busy_n), 32'd2);
    check("z_dout", 32'(z_data_out), 32'h11);
    @(negedge clock);
    check("z_ready_end", 32'(z_mem_ready), 32'd0);
    check("z_busy_end", 32'(z_busy), 32'd0);
    check("z_err", 32'(z_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
